// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: two requesters share one logical/shift unit.
// A round-robin grant happens only in IDLE. Logical ops finish in one cycle.
// Shifts move one bit position per cycle. The result is held until the
// consumer takes it.
module alu_op_arbiter #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_A,
  input  logic [width-1:0] req0_B,
  input  logic [2:0]       req0_operation,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_A,
  input  logic [width-1:0] req1_B,
  input  logic [2:0]       req1_operation,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] res_Y,
  output logic             res_id,
  output logic             res_err
);

  localparam int CNT_W = $clog2(width + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(width);
  localparam logic [width-1:0] B_MAX   = width'(width);

  typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic [CNT_W-1:0] cnt;
  logic             dir;
  logic [width-1:0] y;
  logic             id;
  logic             err;

  logic             gnt0, gnt1, gnt, gnt_id;
  logic [width-1:0] sel_a, sel_b;
  logic [2:0]       sel_op;
  logic             sel_shift;
  logic [CNT_W-1:0] sel_cnt;

  // The single-cycle ops. Shift codes and illegal codes return zero here.
  function automatic logic [width-1:0] logic_op(input logic [2:0] op,
                                                input logic [width-1:0] a,
                                                input logic [width-1:0] b);
    logic [width-1:0] r;
    case (op)
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    return (op[2:1] == 2'b00);
  endfunction

  // One zero-filled shift step. When dir is 1 the shift goes right.
  function automatic logic [width-1:0] shift_one(input logic [width-1:0] v,
                                                 input logic dir_r);
    return dir_r ? {1'b0, v[width-1:1]} : {v[width-2:0], 1'b0};
  endfunction

  // Round-robin grant. It is only possible in IDLE and is blocked while reset is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && (!ptr || !req1_valid)) gnt0 = 1'b1;
      else if (req1_valid)                     gnt1 = 1'b1;
    end
  end

  assign gnt       = gnt0 | gnt1;
  assign gnt_id    = gnt1;
  assign sel_a     = gnt1 ? req1_A : req0_A;
  assign sel_b     = gnt1 ? req1_B : req0_B;
  assign sel_op    = gnt1 ? req1_operation : req0_operation;
  assign sel_shift = (sel_op[2:1] == 2'b11);
  // Shift amounts of width or more saturate, so the whole word shifts out.
  assign sel_cnt   = (sel_b >= B_MAX) ? CNT_MAX : sel_b[CNT_W-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt) begin
          if (sel_shift && sel_cnt != '0) state_nxt = SHIFT;
          else                            state_nxt = RESULT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) state_nxt = RESULT;
      end
      RESULT: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    res_valid  = (state == RESULT);
  end

  // Operand capture at grant, then serial shifting. y doubles as the shift accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
      cnt <= '0;
      dir <= 1'b0;
      y   <= '0;
      id  <= 1'b0;
      err <= 1'b0;
    end else if (gnt) begin
      ptr <= ~gnt_id;
      id  <= gnt_id;
      dir <= sel_op[0];
      if (sel_shift) begin
        y   <= sel_a;
        cnt <= sel_cnt;
        err <= 1'b0;
      end else begin
        y   <= logic_op(sel_op, sel_a, sel_b);
        cnt <= '0;
        err <= is_illegal(sel_op);
      end
    end else if (state == SHIFT) begin
      y   <= shift_one(y, dir);
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign res_Y   = y;
  assign res_id  = id;
  assign res_err = err;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Testbench for alu_op_arbiter. A transaction-level reference model checks
// every cycle. Directed scenarios check results against literal expectations.
module tb_alu_op_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
  logic [2:0]   req0_operation, req1_operation;
  logic         res_valid, res_ready, res_id, res_err;
  logic [W-1:0] res_Y;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_op_arbiter #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A),
    .req0_B(req0_B), .req0_operation(req0_operation),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A),
    .req1_B(req1_B), .req1_operation(req1_operation),
    .res_valid(res_valid), .res_ready(res_ready), .res_Y(res_Y),
    .res_id(res_id), .res_err(res_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result of one operation, straight from the opcode table
  function automatic logic [W-1:0] model_result(input logic [2:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    case (op)
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << b;
      3'd7:    return a >> b;
      default: return '0;
    endcase
  endfunction

  // Transaction model: busy flag, cycles left before the result shows, result fields
  bit           m_busy = 0;
  int           m_wait = 0;
  logic [W-1:0] m_y;
  bit           m_id, m_err, m_ptr = 0;
  bit           g0, g1;
  logic [W-1:0] ma, mb;
  logic [2:0]   mop;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid",  res_valid,  0);
      check("rst_Y",      res_Y,      0);
      check("rst_id",     res_id,     0);
      check("rst_err",    res_err,    0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      m_busy = 0;
      m_ptr  = 0;
    end else begin
      g0 = !m_busy && req0_valid && (!m_ptr || !req1_valid);
      g1 = !m_busy && req1_valid && !g0;
      check("m_ready0", req0_ready, g0);
      check("m_ready1", req1_ready, g1);
      check("m_valid",  res_valid, m_busy && m_wait == 0);
      if (m_busy && m_wait == 0) begin
        check("m_Y",   res_Y,   m_y);
        check("m_id",  res_id,  m_id);
        check("m_err", res_err, m_err);
      end
      if (m_busy) begin
        if (m_wait > 0)     m_wait--;
        else if (res_ready) m_busy = 0;
      end else if (g0 || g1) begin
        ma     = g1 ? req1_A : req0_A;
        mb     = g1 ? req1_B : req0_B;
        mop    = g1 ? req1_operation : req0_operation;
        m_y    = model_result(mop, ma, mb);
        m_err  = (mop < 3'd2);
        m_wait = (mop >= 3'd6) ? ((int'(mb) >= W) ? W : int'(mb)) : 0;
        m_id   = g1;
        m_ptr  = !g1;
        m_busy = 1;
      end
    end
  end

  // Issue one request alone, then check its result against literal values and the latency
  task automatic issue(input string name, input bit id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] op,
                       input logic [W-1:0] ey, input bit eerr, input int elat);
    int n;
    bit got;
    if (id) begin
      req1_valid = 1; req1_A = a; req1_B = b; req1_operation = op;
    end else begin
      req0_valid = 1; req0_A = a; req0_B = b; req0_operation = op;
    end
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (id ? req1_ready : req0_ready) got = 1;
    end
    check({name, "_accept"}, got, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (res_valid) got = 1;
    end
    check({name, "_latency"}, n, elat);
    check({name, "_Y"}, res_Y, ey);
    check({name, "_err"}, res_err, eerr);
    check({name, "_id"}, res_id, id);
    @(posedge clk); #1;
  endtask

  int n;
  bit got;

  initial begin
    rst = 1; res_ready = 1;
    req0_valid = 0; req0_A = '0; req0_B = '0; req0_operation = '0;
    req1_valid = 0; req1_A = '0; req1_B = '0; req1_operation = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset during a shift: the operation is aborted and nothing is presented
    req0_valid = 1; req0_A = 4'b1011; req0_B = 4'd3; req0_operation = 3'b110;
    n = 0; got = 0;
    while (!got && n < 20) begin @(negedge clk); n++; if (req0_ready) got = 1; end
    check("rs_accept", got, 1);
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    req0_valid = 1; req0_A = 4'b1100; req0_B = 4'b1010; req0_operation = 3'b010;
    req1_valid = 1; req1_A = 4'b0101; req1_B = 4'b0011; req1_operation = 3'b100;
    #1;
    check("rs_now_valid",  res_valid,  0);
    check("rs_now_Y",      res_Y,      0);
    check("rs_now_ready0", req0_ready, 0);
    check("rs_now_ready1", req1_ready, 0);
    @(posedge clk); #1 rst = 0;

    // Both requesters stay valid: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      n = 0; got = 0;
      while (!got && n < 20) begin
        @(negedge clk); n++;
        if (req0_ready || req1_ready) got = 1;
      end
      check("arb_got", got, 1);
      check("arb_grant", req1_ready, i % 2);
      n = 0; got = 0;
      while (!got && n < 20) begin @(negedge clk); n++; if (res_valid) got = 1; end
      check("arb_res_id", res_id, i % 2);
      check("arb_res_Y", res_Y, (i % 2) ? 4'b0110 : 4'b1000);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;

    // Back-pressure: the result holds while res_ready is low, then requester 1 is granted
    res_ready = 0;
    req0_valid = 1; req0_A = 4'b1100; req0_B = 4'b0011; req0_operation = 3'b011;
    req1_valid = 1; req1_A = 4'b1111; req1_B = 4'b0101; req1_operation = 3'b010;
    n = 0; got = 0;
    while (!got && n < 20) begin @(negedge clk); n++; if (req0_ready) got = 1; end
    check("bp_accept0", got, 1);
    @(posedge clk); #1 req0_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",  res_valid,  1);
      check("bp_Y",      res_Y,      4'b1111);
      check("bp_ready0", req0_ready, 0);
      check("bp_ready1", req1_ready, 0);
    end
    @(posedge clk); #1 res_ready = 1;
    @(negedge clk);
    check("bp_last_valid",  res_valid,  1);
    check("bp_last_ready1", req1_ready, 0);
    @(negedge clk);
    check("bp_next_ready1", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 0;
    n = 0; got = 0;
    while (!got && n < 20) begin @(negedge clk); n++; if (res_valid) got = 1; end
    check("bp_r1_Y",  res_Y,  4'b0101);
    check("bp_r1_id", res_id, 1);
    @(posedge clk); #1;

    // Logical ops
    issue("and", 0, 4'b1100, 4'b1010, 3'b010, 4'b1000, 0, 1);
    issue("or",  0, 4'b1100, 4'b1010, 3'b011, 4'b1110, 0, 1);
    issue("xor", 0, 4'b1100, 4'b1010, 3'b100, 4'b0110, 0, 1);
    issue("not", 0, 4'b1100, 4'b1010, 3'b101, 4'b0011, 0, 1);

    // Shifts, including a zero amount and an amount of at least the width
    issue("shl2",  0, 4'b1011, 4'd2,    3'b110, 4'b1100, 0, 3);
    issue("shr1",  0, 4'b1011, 4'd1,    3'b111, 4'b0101, 0, 2);
    issue("shl0",  0, 4'b1011, 4'd0,    3'b110, 4'b1011, 0, 1);
    issue("shl9",  0, 4'b1011, 4'b1001, 3'b110, 4'b0000, 0, 5);
    issue("shr4",  1, 4'b1111, 4'd4,    3'b111, 4'b0000, 0, 5);
    issue("shr3",  1, 4'b1000, 4'd3,    3'b111, 4'b0001, 0, 4);

    // Illegal opcodes
    issue("ill1", 1, 4'b1111, 4'b1111, 3'b001, 4'b0000, 1, 1);
    issue("ill0", 0, 4'b0110, 4'b0001, 3'b000, 4'b0000, 1, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
